// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parameterised serial pattern detector with saturating match counter
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 'b1010,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               clr_count,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam int            FW       = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pat_q;
    logic [PAT_LEN-2:0] hist_q;
    logic [FW-1:0]      fill_q;

    logic               accept;
    logic               full;
    logic               match;
    logic [PAT_LEN-1:0] window;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cnt_max;

    // The candidate window is the held history with the incoming bit as its LSB.
    assign window  = {hist_q, x};
    assign accept  = x_valid & ~pat_load;
    assign full    = (fill_q == FILL_MAX);
    assign match   = accept & full & (window == pat_q);
    assign cnt_inc = match_count + CNT_W'(1);
    assign cnt_max = &match_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            z      <= 1'b0;
        end else begin
            z <= match;
            if (pat_load) begin
                pat_q  <= pat_in;
                hist_q <= '0;
                fill_q <= '0;
            end else if (x_valid) begin
                hist_q <= window[PAT_LEN-2:0];
                // Non-overlapping mode restarts the fill so no matched bit is reused.
                if (match && !overlap) begin
                    fill_q <= '0;
                end else if (!full) begin
                    fill_q <= fill_q + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_count) begin
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (match && !cnt_max) begin
            match_count <= cnt_inc;
            count_sat   <= &cnt_inc;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param against a bit-queue reference model
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       overlap = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       clr_count = 1'b0;

    logic       z_a, sat_a, z_b, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .clr_count(clr_count),
        .z(z_a), .match_count(cnt_a), .count_sat(sat_a)
    );

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .clr_count(clr_count),
        .z(z_b), .match_count(cnt_b), .count_sat(sat_b)
    );

    typedef struct {
        logic z;
        int   ca;
        logic sa;
        int   cb;
        logic sb;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   z_seen = 0;

    // Reference model: the accepted bits since the last reset/load/non-overlap match.
    logic       bits[$];
    logic [3:0] m_pat = 4'b1010;
    int         m_ca = 0;
    int         m_cb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic bx, input logic bv, input logic bov, input logic bpl,
                        input logic [3:0] bpi, input logic bclr, input logic brst);
        exp_t       e;
        logic       mz;
        logic [3:0] w;
        int         n;
        @(negedge clk);
        x = bx; x_valid = bv; overlap = bov; pat_load = bpl;
        pat_in = bpi; clr_count = bclr; reset = brst;
        mz = 1'b0;
        if (brst) begin
            bits.delete();
            m_pat = 4'b1010;
            m_ca = 0;
            m_cb = 0;
        end else begin
            if (bpl) begin
                m_pat = bpi;
                bits.delete();
            end else if (bv) begin
                bits.push_back(bx);
                n = bits.size();
                if (n >= 4) begin
                    for (int i = 0; i < 4; i++) w[3-i] = bits[n-4+i];
                    if (w == m_pat) begin
                        mz = 1'b1;
                        if (!bov) bits.delete();
                    end
                end
                while (bits.size() > 3) void'(bits.pop_front());
            end
            if (bclr) begin
                m_ca = 0;
                m_cb = 0;
            end else if (mz) begin
                m_ca = (m_ca < 255) ? m_ca + 1 : 255;
                m_cb = (m_cb < 3) ? m_cb + 1 : 3;
            end
        end
        e.z = mz; e.ca = m_ca; e.sa = (m_ca == 255); e.cb = m_cb; e.sb = (m_cb == 3);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    endtask

    task automatic bit_in(input logic b, input logic ov);
        step(b, 1'b1, ov, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic gap();
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    // Monitor: compares every cycle's outputs against the next scoreboard entry.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("z_a", 32'(z_a), 32'(e.z));
            chk("count_a", 32'(cnt_a), 32'(e.ca));
            chk("sat_a", 32'(sat_a), 32'(e.sa));
            chk("z_b", 32'(z_b), 32'(e.z));
            chk("count_b", 32'(cnt_b), 32'(e.cb));
            chk("sat_b", 32'(sat_b), 32'(e.sb));
            if (z_a === 1'b1) z_seen++;
        end
    end

    initial begin
        int         base;
        logic [7:0] s10 = 8'b10101010;
        logic [3:0] s0110 = 4'b0110;

        do_reset();
        gap();
        chk("reset_z", 32'(z_a), 32'd0);
        chk("reset_count", 32'(cnt_a), 32'd0);

        do_reset();
        base = z_seen;
        for (int i = 0; i < 6; i++) bit_in(s10[7-i], 1'b1);
        gap();
        chk("overlap_pulses", 32'(z_seen - base), 32'd2);
        chk("overlap_count", 32'(cnt_a), 32'd2);

        do_reset();
        base = z_seen;
        for (int i = 0; i < 8; i++) bit_in(s10[7-i], 1'b0);
        gap();
        chk("nonoverlap_pulses", 32'(z_seen - base), 32'd2);
        chk("nonoverlap_count", 32'(cnt_a), 32'd2);

        do_reset();
        base = z_seen;
        bit_in(1'b1, 1'b1); gap(); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        gap(); gap(); bit_in(1'b0, 1'b1); gap();
        chk("gap_pulses", 32'(z_seen - base), 32'd1);

        do_reset();
        base = z_seen;
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bit_in(s0110[3-i], 1'b1);
        gap();
        chk("load_pulses", 32'(z_seen - base), 32'd1);

        do_reset();
        for (int i = 0; i < 12; i++) bit_in(s10[7-(i%8)], 1'b1);
        gap();
        chk("sat_count_b", 32'(cnt_b), 32'd3);
        chk("sat_flag_b", 32'(sat_b), 32'd1);
        base = z_seen;
        bit_in(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        gap();
        chk("clr_pulse", 32'(z_seen - base), 32'd1);
        chk("clr_count_b", 32'(cnt_b), 32'd0);
        chk("clr_sat_b", 32'(sat_b), 32'd0);

        do_reset();
        base = z_seen;
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        do_reset();
        bit_in(1'b0, 1'b1);
        gap();
        chk("midreset_pulses", 32'(z_seen - base), 32'd0);
        chk("midreset_count", 32'(cnt_a), 32'd0);
        for (int i = 0; i < 4; i++) bit_in(s10[7-i], 1'b1);
        gap();
        chk("midreset_pattern", 32'(z_seen - base), 32'd1);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 75),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 2),
                 4'($urandom),
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 199) < 1));
        end
        gap();
        gap();
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4, meaning pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1010, meaning the pattern loaded at reset; MSB is the first bit received.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the match counter width (legal range 1..32).
REQ-004 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port x  input  1  serial data bit.
REQ-007 The block SHALL have port x_valid  input  1  x is accepted on this edge when high.
REQ-008 The block SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled at each match.
REQ-009 The block SHALL have port pat_load  input  1  load a new pattern from pat_in.
REQ-010 The block SHALL have port pat_in  input  PAT_LEN  new pattern value, MSB first.
REQ-011 The block SHALL have port clr_count  input  1  clear match_count and count_sat.
REQ-012 The block SHALL have port z  output  1  registered one-cycle match pulse.
REQ-013 The block SHALL have port match_count  output  CNT_W  saturating count of matches.
REQ-014 The block SHALL have port count_sat  output  1  high once match_count has reached all-ones.

Function
REQ-015 The block SHALL keep a PAT_LEN-1 bit history register and a fill counter (0..PAT_LEN-1) of valid bits held.
REQ-016 On an edge with x_valid=1 and pat_load=0, the block SHALL shift x into the history LSB and increment fill, saturating at PAT_LEN-1.
REQ-017 A match SHALL occur on an accepting edge when fill = PAT_LEN-1 and {history, x} equals the pattern register.
REQ-018 On a match, z SHALL be 1 in the cycle following the completing edge; in every other cycle z SHALL be 0.
REQ-019 Latency SHALL be exactly one clock from the edge accepting the last pattern bit to z high.
REQ-020 On a match with overlap=1, the history and fill SHALL update per REQ-016 so that suffix bits count toward the next match.
REQ-021 On a match with overlap=0, fill SHALL be cleared to 0 so that no bit of the matched window is reused.
REQ-022 Cycles with x_valid=0 SHALL leave history, fill and counter unchanged and SHALL drive z to 0 in the following cycle.
REQ-023 On pat_load=1, the block SHALL set the pattern register to pat_in, clear history and fill, and drive z to 0 the next cycle; x is ignored that cycle and match_count is unchanged.
REQ-024 On a match, match_count SHALL increment by 1 unless it is already all-ones, in which case it holds; count_sat SHALL set when the count becomes all-ones.
REQ-025 On clr_count=1, the block SHALL zero match_count and count_sat; a simultaneous match still pulses z but is not counted.
REQ-026 Priority SHALL be reset > pat_load > x_valid for history/fill/pattern, and reset > clr_count > increment for the counter.

Reset
REQ-027 On reset=1 at an edge, the pattern register SHALL be set to PATTERN, history to 0, and fill to 0.
REQ-028 On reset=1 at an edge, z SHALL be 0, match_count 0 and count_sat 0 from the following cycle; all other inputs are ignored.
REQ-029 Reset mid-stream SHALL discard partial matches; bits accepted before reset SHALL never contribute to a match.

Verification (PAT_LEN=4, PATTERN=1010, CNT_W=8 unless stated)
REQ-030 The bench SHALL check: overlap=1, x_valid=1, bits 1,0,1,0,1,0 -> z high after the 4th and 6th bits; match_count=2.
REQ-031 The bench SHALL check: overlap=0, bits 1,0,1,0,1,0,1,0 -> z high after the 4th and 8th bits only; match_count=2.
REQ-032 The bench SHALL check: bits 1,-,0,1,-,-,0 (- means x_valid=0, x random) -> one z pulse, one cycle after the final 0; z=0 during gaps.
REQ-033 The bench SHALL check: bits 1,0,1, then pat_load with pat_in=0110, then 0,1,1,0 -> exactly one z after the last 0; no match from the pre-load bits.
REQ-034 The bench SHALL check: CNT_W=2, overlap=1, bits 1,0 repeated for 5 matches -> match_count=3 and count_sat=1 after the 3rd match; then clr_count asserted on the edge of a further match -> z=1, match_count=0, count_sat=0.
REQ-035 The bench SHALL check: bits 1,0,1, then reset, then 0 -> no z; z=0, match_count=0 and pattern=1010 after reset.
